// File: rtl/interrupt_controller_pkg.sv
// Shared vector constants, FSM state encoding and vector-range helper for the interrupt controller.
package interrupt_controller_pkg;

  localparam logic [5:0] NMI_VEC_LSB   = 6'd62;
  localparam logic [5:0] RESET_VEC_LSB = 6'd63;

  typedef enum logic [1:0] {
    INTC_IDLE = 2'd0,
    INTC_REQ  = 2'd1,
    INTC_ACK  = 2'd2
  } intc_state_e;

  // Maskable vectors must sit below NMI, which itself sits below the reset vector.
  function automatic logic vector_in_range(input int base, input int num);
    return (num >= 1) && (num <= 16) && (base >= 0) &&
           (base + num <= int'(NMI_VEC_LSB)) && (NMI_VEC_LSB < RESET_VEC_LSB);
  endfunction

endpackage

// File: rtl/intc_priority_encoder.sv
// Highest-index-first priority encoder with a valid flag; purely combinational.
module intc_priority_encoder #(
  parameter int WIDTH = 16,
  parameter int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0] i_req,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_valid
);

  // Ascending scan so the last (highest) set bit overwrites lower ones.
  always_comb begin
    o_idx   = '0;
    o_valid = |i_req;
    for (int i = 0; i < WIDTH; i++) begin
      o_idx = i_req[i] ? IDX_W'(i) : o_idx;
    end
  end

endmodule

// File: rtl/interrupt_controller.sv
// Fixed-priority interrupt controller feeding the CPU's NMI/INT/IntAddrLSBs inputs.
// Optional input synchronisers are enabled with the INTC_SYNC_EN macro.
module interrupt_controller
  import interrupt_controller_pkg::*;
#(
  parameter int NUM_SRC  = 16,
  parameter int VEC_BASE = 46
) (
  input  logic               MCLK,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] IRQ,
  input  logic               NMI_IN,
  input  logic               INTACK,
  output logic               NMI,
  output logic               INT,
  output logic [5:0]         IntAddrLSBs,
  output logic [NUM_SRC-1:0] IRQ_CLR
);

  localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam logic [NUM_SRC-1:0] ONE_SRC = NUM_SRC'(1);

  if (!vector_in_range(VEC_BASE, NUM_SRC)) begin : g_bad_vec
    $error("interrupt_controller: VEC_BASE+NUM_SRC must not exceed 62 and NUM_SRC must be 1..16");
  end

  logic [NUM_SRC-1:0] w_irq;
  logic               w_nmi_in;

`ifdef INTC_SYNC_EN
  logic [NUM_SRC-1:0] r_irq_s1, r_irq_s2;
  logic               r_nmi_s1, r_nmi_s2;

  // Two-flop synchronisers for asynchronous request sources.
  always_ff @(posedge MCLK or negedge reset) begin
    if (!reset) begin
      r_irq_s1 <= '0;
      r_irq_s2 <= '0;
      r_nmi_s1 <= 1'b0;
      r_nmi_s2 <= 1'b0;
    end else begin
      r_irq_s1 <= IRQ;
      r_irq_s2 <= r_irq_s1;
      r_nmi_s1 <= NMI_IN;
      r_nmi_s2 <= r_nmi_s1;
    end
  end

  assign w_irq    = r_irq_s2;
  assign w_nmi_in = r_nmi_s2;
`else
  assign w_irq    = IRQ;
  assign w_nmi_in = NMI_IN;
`endif

  intc_state_e        r_state, w_state_nxt;
  logic               r_nmi_prev, r_nmi_pend, w_nmi_pend_nxt;
  logic               w_nmi_nxt, w_int_nxt;
  logic [5:0]         w_vec_nxt;
  logic [NUM_SRC-1:0] w_clr_nxt;

  logic [IDX_W-1:0]   w_enc_idx;
  logic               w_enc_valid;
  logic               w_nmi_edge, w_nmi_req, w_req;
  logic [5:0]         w_win_vec, w_cur_idx;

  intc_priority_encoder #(.WIDTH(NUM_SRC), .IDX_W(IDX_W)) u_prio (
    .i_req   (w_irq),
    .o_idx   (w_enc_idx),
    .o_valid (w_enc_valid)
  );

  // An edge arriving this cycle competes immediately so NMI latency matches IRQ latency.
  assign w_nmi_edge = w_nmi_in & ~r_nmi_prev;
  assign w_nmi_req  = r_nmi_pend | w_nmi_edge;
  assign w_req      = w_nmi_req | w_enc_valid;
  assign w_win_vec  = w_nmi_req ? NMI_VEC_LSB : (6'(VEC_BASE) + 6'(w_enc_idx));
  assign w_cur_idx  = IntAddrLSBs - 6'(VEC_BASE);

  // Next-state and next-output logic for the request/acknowledge handshake.
  always_comb begin
    w_state_nxt    = r_state;
    w_nmi_nxt      = NMI;
    w_int_nxt      = INT;
    w_vec_nxt      = IntAddrLSBs;
    w_clr_nxt      = '0;
    w_nmi_pend_nxt = w_nmi_req;
    case (r_state)
      INTC_IDLE: begin
        if (w_req) begin
          w_nmi_nxt   = w_nmi_req;
          w_int_nxt   = ~w_nmi_req;
          w_vec_nxt   = w_win_vec;
          w_state_nxt = INTC_REQ;
        end else begin
          w_nmi_nxt = 1'b0;
          w_int_nxt = 1'b0;
        end
      end
      INTC_REQ: begin
        if (INTACK) begin
          // The source named by the registered vector is the one serviced; a fresh edge re-arms NMI.
          if (NMI) begin
            w_nmi_pend_nxt = w_nmi_edge;
          end else begin
            w_clr_nxt = ONE_SRC << w_cur_idx;
          end
          w_nmi_nxt   = 1'b0;
          w_int_nxt   = 1'b0;
          w_state_nxt = INTC_ACK;
        end else if (w_req) begin
          w_nmi_nxt = w_nmi_req;
          w_int_nxt = ~w_nmi_req;
          w_vec_nxt = w_win_vec;
        end else begin
          w_nmi_nxt   = 1'b0;
          w_int_nxt   = 1'b0;
          w_state_nxt = INTC_IDLE;
        end
      end
      INTC_ACK: begin
        w_nmi_nxt = 1'b0;
        w_int_nxt = 1'b0;
        if (!INTACK) begin
          w_state_nxt = INTC_IDLE;
        end else begin
          w_state_nxt = INTC_ACK;
        end
      end
      default: begin
        w_nmi_nxt   = 1'b0;
        w_int_nxt   = 1'b0;
        w_state_nxt = INTC_IDLE;
      end
    endcase
  end

  // State, NMI capture and registered CPU-facing outputs.
  always_ff @(posedge MCLK or negedge reset) begin
    if (!reset) begin
      r_state     <= INTC_IDLE;
      r_nmi_prev  <= 1'b1;
      r_nmi_pend  <= 1'b0;
      NMI         <= 1'b0;
      INT         <= 1'b0;
      IntAddrLSBs <= 6'd0;
      IRQ_CLR     <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_nmi_prev  <= w_nmi_in;
      r_nmi_pend  <= w_nmi_pend_nxt;
      NMI         <= w_nmi_nxt;
      INT         <= w_int_nxt;
      IntAddrLSBs <= w_vec_nxt;
      IRQ_CLR     <= w_clr_nxt;
    end
  end

endmodule

// File: tb/tb_interrupt_controller.sv
// Self-checking bench: directed scenarios plus randomized traffic against a behavioural model.
module tb_interrupt_controller;

  logic        MCLK = 1'b0;
  logic        reset;
  logic [15:0] IRQ;
  logic        NMI_IN;
  logic        INTACK;
  logic        NMI;
  logic        INT;
  logic [5:0]  IntAddrLSBs;
  logic [15:0] IRQ_CLR;

  always #5 MCLK = ~MCLK;

  interrupt_controller dut (
    .MCLK        (MCLK),
    .reset       (reset),
    .IRQ         (IRQ),
    .NMI_IN      (NMI_IN),
    .INTACK      (INTACK),
    .NMI         (NMI),
    .INT         (INT),
    .IntAddrLSBs (IntAddrLSBs),
    .IRQ_CLR     (IRQ_CLR)
  );

  int checks   = 0;
  int failures = 0;

  // Model: phase 0 = waiting, 1 = request presented, 2 = acknowledged.
  int          m_phase;
  bit          m_pend;
  bit          m_prev;
  logic        exp_nmi;
  logic        exp_int;
  logic [5:0]  exp_vec;
  logic [15:0] exp_clr;

  logic prev_dut_nmi = 1'b0;
  int   nmi_rises    = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
    end
  endtask

  function automatic int top_bit(input logic [15:0] v);
    int r = -1;
    for (int i = 0; i < 16; i++) if (v[i]) r = i;
    return r;
  endfunction

  task automatic model_reset();
    m_phase = 0;
    m_pend  = 1'b0;
    m_prev  = 1'b1;
    exp_nmi = 1'b0;
    exp_int = 1'b0;
    exp_vec = 6'd0;
    exp_clr = 16'd0;
  endtask

  task automatic model_tick(input logic [15:0] irq, input logic nmi_in, input logic ack);
    bit          nmi_rise, pend_eff, has;
    int          hb;
    logic [5:0]  wv;
    logic [15:0] nclr;
    nmi_rise = nmi_in && !m_prev;
    pend_eff = m_pend || nmi_rise;
    hb       = top_bit(irq);
    has      = pend_eff || (hb >= 0);
    wv       = pend_eff ? 6'd62 : 6'(46 + hb);
    nclr     = 16'd0;
    case (m_phase)
      0: begin
        if (has) begin
          exp_nmi = pend_eff; exp_int = !pend_eff; exp_vec = wv; m_phase = 1;
        end else begin
          exp_nmi = 1'b0; exp_int = 1'b0;
        end
      end
      1: begin
        if (ack) begin
          if (exp_nmi) pend_eff = nmi_rise;
          else nclr = 16'd1 << (exp_vec - 6'd46);
          exp_nmi = 1'b0; exp_int = 1'b0; m_phase = 2;
        end else if (has) begin
          exp_nmi = pend_eff; exp_int = !pend_eff; exp_vec = wv;
        end else begin
          exp_nmi = 1'b0; exp_int = 1'b0; m_phase = 0;
        end
      end
      default: begin
        exp_nmi = 1'b0; exp_int = 1'b0;
        if (!ack) m_phase = 0;
      end
    endcase
    exp_clr = nclr;
    m_pend  = pend_eff;
    m_prev  = nmi_in;
  endtask

  task automatic compare();
    chk("nmi", NMI, exp_nmi);
    chk("int", INT, exp_int);
    chk("vec", IntAddrLSBs, exp_vec);
    chk("irq_clr", IRQ_CLR, exp_clr);
    chk("clr_onehot0", ($countones(IRQ_CLR) <= 1), 1);
    chk("nmi_int_excl", (NMI & INT), 0);
    if (!prev_dut_nmi && NMI) nmi_rises++;
    prev_dut_nmi = NMI;
  endtask

  // Called at a negedge: drive, predict, then check after the next posedge.
  task automatic step(input logic [15:0] irq, input logic nmi_in, input logic ack);
    IRQ    = irq;
    NMI_IN = nmi_in;
    INTACK = ack;
    model_tick(irq, nmi_in, ack);
    @(negedge MCLK);
    compare();
  endtask

  logic [15:0] r_irq;
  bit          r_nmi;
  bit          r_ack;

  initial begin
    reset = 1'b0; IRQ = 16'd0; NMI_IN = 1'b0; INTACK = 1'b0;
    model_reset();
    @(negedge MCLK);
    @(negedge MCLK);
    compare();
    chk("rst_int", INT, 0);
    chk("rst_vec", IntAddrLSBs, 0);
    reset = 1'b1;

    // Single source service.
    step(16'h0008, 1'b0, 1'b0);
    chk("s1_int", INT, 1);
    chk("s1_vec", IntAddrLSBs, 49);
    step(16'h0008, 1'b0, 1'b1);
    chk("s1_clr", IRQ_CLR, 16'h0008);
    chk("s1_int_drop", INT, 0);
    step(16'h0000, 1'b0, 1'b0);
    chk("s1_clr_once", IRQ_CLR, 0);
    step(16'h0000, 1'b0, 1'b0);

    // Two sources: higher wins, lower follows.
    step(16'h0204, 1'b0, 1'b0);
    chk("s2_vec", IntAddrLSBs, 55);
    step(16'h0204, 1'b0, 1'b1);
    chk("s2_clr", IRQ_CLR, 16'h0200);
    step(16'h0004, 1'b0, 1'b0);
    step(16'h0004, 1'b0, 1'b0);
    chk("s2_int2", INT, 1);
    chk("s2_vec2", IntAddrLSBs, 48);
    step(16'h0004, 1'b0, 1'b1);
    step(16'h0000, 1'b0, 1'b0);
    step(16'h0000, 1'b0, 1'b0);

    // NMI preempts a pending IRQ; level held high yields one NMI.
    nmi_rises = 0;
    step(16'h0008, 1'b0, 1'b0);
    step(16'h0008, 1'b1, 1'b0);
    chk("s3_nmi", NMI, 1);
    chk("s3_int", INT, 0);
    chk("s3_vec", IntAddrLSBs, 62);
    step(16'h0008, 1'b1, 1'b1);
    chk("s3_noclr", IRQ_CLR, 0);
    step(16'h0008, 1'b1, 1'b0);
    step(16'h0008, 1'b1, 1'b0);
    chk("s3_int_back", INT, 1);
    chk("s3_vec_back", IntAddrLSBs, 49);
    step(16'h0008, 1'b1, 1'b1);
    chk("s3_clr", IRQ_CLR, 16'h0008);
    for (int k = 0; k < 15; k++) step(16'h0000, 1'b1, (k % 4) == 1);
    chk("s3_one_nmi", nmi_rises, 1);
    step(16'h0000, 1'b0, 1'b0);

    // Withdrawn request, then a late acknowledge.
    step(16'h0020, 1'b0, 1'b0);
    chk("s5_vec", IntAddrLSBs, 51);
    step(16'h0000, 1'b0, 1'b0);
    chk("s5_int_fall", INT, 0);
    step(16'h0000, 1'b0, 1'b1);
    chk("s5_late_ack", IRQ_CLR, 0);
    step(16'h0000, 1'b0, 1'b0);

    // Asynchronous reset while in the acknowledge phase.
    step(16'h0010, 1'b0, 1'b0);
    step(16'h0010, 1'b0, 1'b1);
    IRQ = 16'h0000;
    reset = 1'b0;
    #2;
    model_reset();
    compare();
    chk("s6_clr_zero", IRQ_CLR, 0);
    @(negedge MCLK);
    compare();
    reset = 1'b1;
    step(16'h0000, 1'b0, 1'b1);
    step(16'h0000, 1'b0, 1'b0);
    chk("s6_idle", INT, 0);

    // NMI_IN held high through reset must not trigger.
    reset = 1'b0; NMI_IN = 1'b1;
    #2;
    model_reset();
    @(negedge MCLK);
    compare();
    reset = 1'b1;
    for (int k = 0; k < 3; k++) step(16'h0000, 1'b1, 1'b0);
    chk("s4_no_nmi", NMI, 0);
    step(16'h0000, 1'b0, 1'b0);

    // Randomized traffic with a peripheral that clears on IRQ_CLR.
    r_irq = 16'd0; r_nmi = 1'b0; r_ack = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      r_irq = r_irq & ~exp_clr;
      if ($urandom_range(0, 7) == 0) r_irq[$urandom_range(0, 15)] = 1'b1;
      if ($urandom_range(0, 31) == 0) r_irq = 16'd0;
      if ($urandom_range(0, 9) == 0) r_nmi = !r_nmi;
      if (r_ack) r_ack = ($urandom_range(0, 1) == 1);
      else r_ack = ($urandom_range(0, 3) == 0);
      step(r_irq, r_nmi, r_ack);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
